ahb_axi_burst_encoder: RTL and testbench
========================================

# ahb_axi_burst_encoder

Request-side burst encoder for the AHB-to-AXI bridge: sits behind the AHB slave port and turns each AHB address phase (HTRANS/HBURST/HSIZE/HADDR/HWRITE) into one AXI AW or AR request carrying AxLEN/AxBURST/AxSIZE/AxADDR. It tracks the SEQ beats of fixed-length bursts with a beat counter, stalls AHB through HREADYOUT while the AXI address handshake is pending, and flags early-terminated bursts. Data channels are handled by separate blocks; this block owns only the address/burst mapping and its handshake.

## Interface
- ADDR_W, default 32, address width.
- clk  input  1  clock; every register samples on rising edge.
- rst  input  1  reset; synchronous and active-high.
- hsel  input  1  AHB slave select.
- htrans  input  2  AHB transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hburst  input  3  AHB burst: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- hsize  input  3  AHB transfer size.
- haddr  input  ADDR_W  AHB address.
- hwrite  input  1  1 = write, 0 = read.
- hready_in  input  1  AHB bus HREADY.
- hready_out  output  1  slave HREADYOUT; low stalls AHB.
- awvalid / arvalid  output  1 each  AXI address valid.
- awready / arready  input  1 each  AXI address ready.
- awaddr / araddr  output  ADDR_W  request address.
- awlen / arlen  output  4  beats minus one.
- awburst / arburst  output  2  01 = INCR, 10 = WRAP.
- awsize / arsize  output  3  copy of hsize.
- burst_abort  output  1  one-cycle pulse: fixed-length burst ended early.

## Operation
- Accepted address phase: hsel & hready_in & hready_out & htrans[1].
- Burst mapping. AxLEN/AxBURST:
  - SINGLE: 0/INCR.
  - INCR (undefined length): 0/INCR, reissued on every accepted NONSEQ and SEQ beat.
  - WRAP4: 3/WRAP. INCR4: 3/INCR.
  - WRAP8: 7/WRAP. INCR8: 7/INCR.
  - WRAP16: 15/WRAP. INCR16: 15/INCR.
- FSM states: IDLE, ADDR, BURST.
- IDLE:
  - Accepted NONSEQ registers the fields, loads remaining = AxLEN, and goes to ADDR.
  - Accepted SEQ in IDLE is ignored.
- ADDR:
  - awvalid is asserted when the registered hwrite = 1; arvalid when it is 0. Never both.
  - Address, len, burst and size stay stable until the matching ready is seen.
  - On the handshake, the FSM goes to BURST if remaining ≠ 0 or the burst is undefined INCR; otherwise it goes to IDLE.
- BURST:
  - Fixed-length burst: each accepted SEQ decrements remaining (4-bit, never below 0). The FSM goes to IDLE when a SEQ is accepted with remaining = 1.
  - Undefined INCR: each accepted SEQ registers a new single-beat request (haddr of that beat) and goes to ADDR.
  - BUSY or IDLE htrans: stay in BURST and hold the counter. For undefined INCR, htrans IDLE returns the FSM to IDLE.
  - Accepted NONSEQ with a fixed-length burst and remaining ≠ 0: pulse burst_abort, discard the old burst, and start the new request (go to ADDR).
  - Accepted NONSEQ in undefined INCR: new request, no abort.
- Reset at any point, including mid-burst or mid-handshake: FSM goes to IDLE, the counter clears, and any pending request is dropped without a handshake.

## Timing
- Reset values:
  - hready_out = 1.
  - awvalid = arvalid = 0.
  - awaddr = araddr = 0, awlen = arlen = 0, awburst = arburst = 01, awsize = arsize = 0.
  - burst_abort = 0.
- Address phase accepted in cycle N: in cycle N+1, axvalid = 1 and hready_out = 0.
- Handshake in cycle M (axvalid & axready): axvalid = 0 and hready_out = 1 in cycle M+1.
- Minimum stall is one cycle. If ready is already high, the request completes in N+1 and AHB resumes in N+2.
- hready_out is low exactly while in ADDR. No new address phase is accepted while it is low.
- burst_abort is asserted in the cycle after the aborting NONSEQ is accepted, for one cycle.

## Test plan
- INCR4 write at haddr 0x100, hsize 2, awready tied high:
  - awvalid for one cycle with awaddr 0x100, awlen 3, awburst 01, awsize 2.
  - hready_out low for one cycle.
  - Three SEQ beats are accepted, then the FSM is in IDLE with no further request.
- WRAP8 read at 0x3C, arready held low for 5 cycles:
  - arvalid and fields (araddr 0x3C, arlen 7, arburst 10) are stable for all 6 cycles.
  - hready_out is low for the same 6 cycles.
  - awvalid stays 0 throughout.
- Undefined INCR, 3 beats at 0x200/0x204/0x208 with a BUSY between beats 2 and 3: three single requests, each with awlen 0, awburst 01, in address order.
- INCR16 broken by a NONSEQ after the 5th beat: burst_abort pulses once, the new request is issued, and there is no stale request.
- rst asserted while in ADDR with arvalid high: next cycle arvalid = 0, hready_out = 1, and a following NONSEQ is handled normally.
- SINGLE write followed back-to-back by a SINGLE read: exactly one awvalid handshake then one arvalid handshake, each with len 0.

Source files
------------

// File: rtl/ahb_axi_burst_encoder.sv
// AHB address-phase to AXI AW/AR request encoder with burst beat tracking.
// Stalls AHB via hready_out while the AXI address handshake is outstanding.
module ahb_axi_burst_encoder #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic              hready_in,
  output logic              hready_out,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [1:0]        awburst,
  output logic [2:0]        awsize,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [1:0]        arburst,
  output logic [2:0]        arsize,
  output logic              burst_abort
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [1:0] AX_INCR   = 2'b01;
  localparam logic [1:0] AX_WRAP   = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        rem_q, rem_d;
  logic [1:0]        kind_q, kind_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              undef_q, undef_d;
  logic              awvalid_q, awvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              hready_q, hready_d;
  logic              abort_q, abort_d;

  logic       accept;
  logic       ax_ready;
  logic       load;
  logic       load_single;
  logic [3:0] map_len;
  logic [1:0] map_kind;

  always_comb begin
    map_len  = 4'd0;
    map_kind = AX_INCR;
    case (hburst)
      3'd2:    begin map_len = 4'd3;  map_kind = AX_WRAP; end
      3'd3:    begin map_len = 4'd3;  map_kind = AX_INCR; end
      3'd4:    begin map_len = 4'd7;  map_kind = AX_WRAP; end
      3'd5:    begin map_len = 4'd7;  map_kind = AX_INCR; end
      3'd6:    begin map_len = 4'd15; map_kind = AX_WRAP; end
      3'd7:    begin map_len = 4'd15; map_kind = AX_INCR; end
      default: begin map_len = 4'd0;  map_kind = AX_INCR; end
    endcase
  end

  assign accept   = hsel & hready_in & hready_q & htrans[1];
  assign ax_ready = write_q ? awready : arready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rem_d       = rem_q;
    kind_d      = kind_q;
    size_d      = size_q;
    write_d     = write_q;
    undef_d     = undef_q;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
    hready_d    = hready_q;
    abort_d     = 1'b0;
    load        = 1'b0;
    load_single = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && htrans == HT_NONSEQ) load = 1'b1;
      end
      S_ADDR: begin
        if (ax_ready) begin
          awvalid_d = 1'b0;
          arvalid_d = 1'b0;
          hready_d  = 1'b1;
          state_d   = (rem_q != 4'd0 || undef_q) ? S_BURST : S_IDLE;
        end
      end
      S_BURST: begin
        if (accept && htrans == HT_NONSEQ) begin
          abort_d = !undef_q && (rem_q != 4'd0);
          load    = 1'b1;
        end else if (accept && htrans == HT_SEQ) begin
          if (undef_q) begin
            load        = 1'b1;
            load_single = 1'b1;
          end else if (rem_q != 4'd0) begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) state_d = S_IDLE;
          end
        end else if (undef_q && hsel && hready_in && htrans == HT_IDLE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An undefined-INCR SEQ beat reissues as a single-beat request, so it keeps undef set.
    if (load) begin
      addr_d    = haddr;
      size_d    = hsize;
      write_d   = hwrite;
      len_d     = load_single ? 4'd0 : map_len;
      kind_d    = load_single ? AX_INCR : map_kind;
      rem_d     = load_single ? 4'd0 : map_len;
      undef_d   = load_single | (hburst == HB_INCR);
      awvalid_d = hwrite;
      arvalid_d = !hwrite;
      hready_d  = 1'b0;
      state_d   = S_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      kind_q    <= AX_INCR;
      size_q    <= '0;
      write_q   <= 1'b0;
      undef_q   <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      hready_q  <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      kind_q    <= kind_d;
      size_q    <= size_d;
      write_q   <= write_d;
      undef_q   <= undef_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      hready_q  <= hready_d;
      abort_q   <= abort_d;
    end
  end

  assign hready_out  = hready_q;
  assign awvalid     = awvalid_q;
  assign arvalid     = arvalid_q;
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign awlen       = len_q;
  assign arlen       = len_q;
  assign awburst     = kind_q;
  assign arburst     = kind_q;
  assign awsize      = size_q;
  assign arsize      = size_q;
  assign burst_abort = abort_q;

endmodule

// File: tb/tb_ahb_axi_burst_encoder.sv
// Self-checking bench for ahb_axi_burst_encoder: directed vector table,
// hand-written corner sequences and randomized bursts against expected requests.
module tb_ahb_axi_burst_encoder;

  localparam int unsigned ADDR_W = 32;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic              hready_in;
  logic              hready_out;
  logic              awvalid, awready, arvalid, arready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0]        awlen, arlen;
  logic [1:0]        awburst, arburst;
  logic [2:0]        awsize, arsize;
  logic              burst_abort;

  int   n_checks  = 0;
  int   n_fail    = 0;
  logic exp_abort = 1'b0;
  logic open_fixed;
  logic dut_idle;

  typedef struct {
    logic [2:0]        burst;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              write;
    int unsigned       delay;
    int unsigned       nseq;
    logic              busy;
    logic [3:0]        exp_len;
    logic [1:0]        exp_kind;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ahb_axi_burst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .haddr(haddr), .hwrite(hwrite), .hready_in(hready_in),
    .hready_out(hready_out),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awburst(awburst), .awsize(awsize),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arburst(arburst), .arsize(arsize),
    .burst_abort(burst_abort)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned beats_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [1:0] kind_of(input logic [2:0] b);
    return (b == 3'd2 || b == 3'd4 || b == 3'd6) ? 2'b10 : 2'b01;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("burst_abort", 64'(burst_abort), 64'(exp_abort));
    exp_abort = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check(name, 64'({hready_out, awvalid, arvalid}), 64'(3'b100));
  endtask

  task automatic issue(input logic [1:0] tr, input logic [2:0] b, input logic [ADDR_W-1:0] a,
                       input logic w, input logic [2:0] s, input logic ab);
    hsel = 1'b1; hready_in = 1'b1; htrans = tr; hburst = b;
    haddr = a; hwrite = w; hsize = s;
    exp_abort = ab;
    tick();
  endtask

  // Request is expected visible now; hold ready low for 'delay' cycles, then complete it.
  task automatic wait_req(input logic [ADDR_W-1:0] a, input logic [3:0] len, input logic [1:0] kind,
                          input logic [2:0] s, input logic w, input int unsigned delay);
    for (int unsigned d = 0; d <= delay; d++) begin
      check("hready_out_stall", 64'(hready_out), 64'(0));
      check("awvalid", 64'(awvalid), 64'(w));
      check("arvalid", 64'(arvalid), 64'(!w));
      if (w) begin
        check("awaddr", 64'(awaddr), 64'(a));
        check("awlen", 64'(awlen), 64'(len));
        check("awburst", 64'(awburst), 64'(kind));
        check("awsize", 64'(awsize), 64'(s));
      end else begin
        check("araddr", 64'(araddr), 64'(a));
        check("arlen", 64'(arlen), 64'(len));
        check("arburst", 64'(arburst), 64'(kind));
        check("arsize", 64'(arsize), 64'(s));
      end
      hsel = 1'b1; hready_in = 1'($urandom); htrans = 2'($urandom);
      haddr = ADDR_W'($urandom);
      awready = w  ? (d == delay) : 1'($urandom);
      arready = !w ? (d == delay) : 1'($urandom);
      tick();
    end
    awready = 1'b0; arready = 1'b0;
    check_quiet("handshake_done");
  endtask

  task automatic run_burst(input logic [2:0] b, input logic [ADDR_W-1:0] a, input logic w,
                           input logic [2:0] s, input int unsigned delay, input int unsigned nseq,
                           input logic busy, input logic [3:0] el, input logic [1:0] ek,
                           input logic ab);
    logic [ADDR_W-1:0] ba;
    issue(T_NONSEQ, b, a, w, s, ab);
    wait_req(a, el, ek, s, w, delay);
    for (int unsigned k = 1; k <= nseq; k++) begin
      ba = a + (ADDR_W'(k) << s);
      if (busy && k >= 2) begin
        hsel = 1'b1; hready_in = 1'b1; htrans = T_BUSY;
        tick();
        check_quiet("busy_beat");
      end
      issue(T_SEQ, b, ba, w, s, 1'b0);
      if (b == 3'd1) wait_req(ba, 4'd0, 2'b01, s, w, delay);
      else           check_quiet("seq_beat");
    end
  endtask

  task automatic stray();
    hsel = 1'b1; hready_in = 1'b1; htrans = T_SEQ; haddr = ADDR_W'($urandom);
    tick();
    check_quiet("stray_seq_ignored");
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; htrans = T_IDLE; hburst = 3'd0; hsize = 3'd0;
    haddr = '0; hwrite = 1'b0; hready_in = 1'b1; awready = 1'b0; arready = 1'b0;

    vecs[0] = '{3'd3, 32'h100,  3'd2, 1'b1, 0, 3,  1'b0, 4'd3,  2'b01};
    vecs[1] = '{3'd4, 32'h3C,   3'd2, 1'b0, 5, 7,  1'b0, 4'd7,  2'b10};
    vecs[2] = '{3'd0, 32'h40,   3'd0, 1'b1, 0, 0,  1'b0, 4'd0,  2'b01};
    vecs[3] = '{3'd0, 32'h44,   3'd1, 1'b0, 1, 0,  1'b0, 4'd0,  2'b01};
    vecs[4] = '{3'd6, 32'h80,   3'd2, 1'b1, 2, 15, 1'b1, 4'd15, 2'b10};
    vecs[5] = '{3'd7, 32'h1000, 3'd3, 1'b0, 0, 15, 1'b0, 4'd15, 2'b01};
    vecs[6] = '{3'd2, 32'h2C,   3'd2, 1'b0, 3, 3,  1'b1, 4'd3,  2'b10};
    vecs[7] = '{3'd5, 32'h400,  3'd1, 1'b1, 1, 7,  1'b0, 4'd7,  2'b01};

    repeat (3) tick();
    check("rst_hready_out", 64'(hready_out), 64'(1));
    check("rst_valids", 64'({awvalid, arvalid}), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("rst_araddr", 64'(araddr), 64'(0));
    check("rst_lens", 64'({awlen, arlen}), 64'(0));
    check("rst_bursts", 64'({awburst, arburst}), 64'(4'b0101));
    check("rst_sizes", 64'({awsize, arsize}), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].burst, vecs[i].addr, vecs[i].write, vecs[i].size, vecs[i].delay,
                vecs[i].nseq, vecs[i].busy, vecs[i].exp_len, vecs[i].exp_kind, 1'b0);
      stray();
    end

    // SINGLE write directly followed by SINGLE read.
    run_burst(3'd0, 32'h50, 1'b1, 3'd2, 0, 0, 1'b0, 4'd0, 2'b01, 1'b0);
    run_burst(3'd0, 32'h54, 1'b0, 3'd2, 0, 0, 1'b0, 4'd0, 2'b01, 1'b0);

    // Undefined INCR, three beats with BUSY between beats 2 and 3, then IDLE.
    run_burst(3'd1, 32'h200, 1'b1, 3'd2, 0, 2, 1'b1, 4'd0, 2'b01, 1'b0);
    hsel = 1'b1; hready_in = 1'b1; htrans = T_IDLE;
    tick();
    check_quiet("incr_idle_end");
    stray();

    // INCR16 cut after its 5th beat by a new NONSEQ.
    run_burst(3'd7, 32'h500, 1'b1, 3'd2, 0, 4, 1'b0, 4'd15, 2'b01, 1'b0);
    run_burst(3'd0, 32'h600, 1'b0, 3'd2, 0, 0, 1'b0, 4'd0, 2'b01, 1'b1);
    stray();

    // Reset while a read request is pending.
    issue(T_NONSEQ, 3'd2, 32'h700, 1'b0, 3'd2, 1'b0);
    check("rst_pre_arvalid", 64'(arvalid), 64'(1));
    rst = 1'b1; arready = 1'b0; hsel = 1'b0; htrans = T_IDLE;
    tick();
    rst = 1'b0;
    check_quiet("rst_in_addr");
    check("rst_in_addr_araddr", 64'(araddr), 64'(0));
    check("rst_in_addr_arlen", 64'(arlen), 64'(0));
    check("rst_in_addr_arburst", 64'(arburst), 64'(2'b01));
    run_burst(3'd3, 32'h710, 1'b0, 3'd2, 1, 3, 1'b0, 4'd3, 2'b01, 1'b0);

    // Reset mid-burst clears the beat counter: the next NONSEQ must not abort.
    run_burst(3'd5, 32'h800, 1'b1, 3'd2, 0, 2, 1'b0, 4'd7, 2'b01, 1'b0);
    rst = 1'b1; hsel = 1'b0;
    tick();
    rst = 1'b0;
    run_burst(3'd0, 32'h900, 1'b1, 3'd0, 0, 0, 1'b0, 4'd0, 2'b01, 1'b0);

    open_fixed = 1'b0;
    dut_idle   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0]        b;
      logic [2:0]        s;
      logic [ADDR_W-1:0] a;
      logic              w;
      logic              bz;
      int unsigned       d;
      int unsigned       n;
      int unsigned       beats;
      int unsigned       gaps;
      b     = 3'($urandom_range(0, 7));
      s     = 3'($urandom_range(0, 2));
      a     = ADDR_W'($urandom) & ~ADDR_W'(7);
      w     = 1'($urandom);
      bz    = 1'($urandom);
      d     = $urandom_range(0, 3);
      beats = beats_of(b);
      if (b == 3'd1)                     n = $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 1) n = beats - 1;
      else                               n = $urandom_range(0, beats - 1);
      run_burst(b, a, w, s, d, n, bz, 4'(beats - 1), kind_of(b), open_fixed);
      open_fixed = (b != 3'd1) && (n < beats - 1);
      dut_idle   = (b != 3'd1) && (n == beats - 1);
      if (b == 3'd1 && $urandom_range(0, 1) == 1) begin
        hsel = 1'b1; hready_in = 1'b1; htrans = T_IDLE;
        tick();
        check_quiet("rand_incr_end");
        dut_idle = 1'b1;
      end
      gaps = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gaps; g++) begin
        hsel      = 1'($urandom);
        hready_in = hsel ? 1'b0 : 1'($urandom);
        htrans    = 2'($urandom);
        haddr     = ADDR_W'($urandom);
        tick();
        check_quiet("rand_gap");
      end
      if (dut_idle && $urandom_range(0, 1) == 1) stray();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
